// File: rtl/vector_writeback_if.sv
// Bundles the two datapath handshakes of the writeback stage:
//   - lane side:  in_valid / in_ready / in_data / in_vd (+ in_mask when
//                 VWB_LANE_MASK_EN is defined)
//   - rf side:    rf_busy / rf_we / rf_waddr / rf_wdata (+ rf_wmask when
//                 VWB_LANE_MASK_EN is defined)
// Modports:
//   slave  - the writeback block (consumes lane results, drives the RF port)
//   master - the surrounding environment (lane array + register file)
interface vector_writeback_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic [AW-1:0]          in_vd;
    logic                   rf_busy;
    logic                   rf_we;
    logic [AW-1:0]          rf_waddr;
    logic [LANES*WIDTH-1:0] rf_wdata;
`ifdef VWB_LANE_MASK_EN
    logic [LANES-1:0]       in_mask;
    logic [LANES-1:0]       rf_wmask;
`endif

    modport slave (
`ifdef VWB_LANE_MASK_EN
        input  in_mask,
        output rf_wmask,
`endif
        input  in_valid,
        input  in_data,
        input  in_vd,
        input  rf_busy,
        output in_ready,
        output rf_we,
        output rf_waddr,
        output rf_wdata
    );

    modport master (
`ifdef VWB_LANE_MASK_EN
        output in_mask,
        input  rf_wmask,
`endif
        output in_valid,
        output in_data,
        output in_vd,
        output rf_busy,
        input  in_ready,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata
    );
endinterface

// File: rtl/vector_writeback.sv
// vector_writeback
//   Collects a LANES*WIDTH lane result word plus its destination register,
//   buffers it in a DEPTH-entry FIFO and drains the FIFO into the vector
//   register file write port. Also answers pending-write hazard queries from
//   issue and keeps a saturating count of completed writes.
//
// Optional feature macro: VWB_LANE_MASK_EN
//   When defined, each entry carries a per-lane write mask (in_mask), the
//   mask is presented with the write (rf_wmask), and entries whose mask is
//   all-zero are drained without raising rf_we and without being counted.
//   When undefined, every entry writes all lanes.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   bus        slave modport of vector_writeback_if (lane input handshake
//              and register file write port)
//   query_vd   in   register the issue stage wants to read
//   query_hit  out  combinational; query_vd has a write pending in the FIFO
//                   or in the rf_we stage
//   wb_count   out  saturating count of cycles with rf_we = 1
//   empty      out  FIFO empty and no rf_we this cycle
module vector_writeback #(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    vector_writeback_if.slave     bus,
    input  logic [AW-1:0]         query_vd,
    output logic                  query_hit,
    output logic [15:0]           wb_count,
    output logic                  empty
);

    localparam int DW = LANES * WIDTH;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0]    data_mem [DEPTH];
    logic [AW-1:0]    vd_mem   [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;

    logic             rf_we_q;
    logic [AW-1:0]    rf_waddr_q;
    logic [DW-1:0]    rf_wdata_q;
    logic [15:0]      wb_count_q;

    logic             full;
    logic             push;
    logic             pop;
    logic             head_writes;

`ifdef VWB_LANE_MASK_EN
    logic [LANES-1:0] mask_mem [DEPTH];
    logic [LANES-1:0] rf_wmask_q;

    // An all-zero mask still drains the entry but must not strobe the RF.
    assign head_writes = (mask_mem[rptr_q] != '0);
    assign bus.rf_wmask = rf_wmask_q;
`else
    assign head_writes = 1'b1;
`endif

    // in_ready depends only on registered occupancy, so a pop in the same
    // cycle never opens the door for a push into a full FIFO.
    assign full         = (count_q == FULL_CNT);
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign pop          = (count_q != '0) && !bus.rf_busy;

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign wb_count     = wb_count_q;
    assign empty        = (count_q == '0) && !rf_we_q;

    // Entry storage; contents are meaningless unless the valid bit is set,
    // so the arrays themselves are not reset.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wptr_q] <= bus.in_data;
            vd_mem[wptr_q]   <= bus.in_vd;
`ifdef VWB_LANE_MASK_EN
            mask_mem[wptr_q] <= bus.in_mask;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_count_q <= '0;
`ifdef VWB_LANE_MASK_EN
            rf_wmask_q <= '0;
`endif
        end else begin
            if (push) begin
                wptr_q          <= wptr_q + PW'(1);
                valid_q[wptr_q] <= 1'b1;
            end

            if (pop) begin
                rptr_q     <= rptr_q + PW'(1);
                rf_waddr_q <= vd_mem[rptr_q];
                rf_wdata_q <= data_mem[rptr_q];
`ifdef VWB_LANE_MASK_EN
                rf_wmask_q <= mask_mem[rptr_q];
`endif
            end

            // Pointers differ whenever push and pop are both active (the FIFO
            // is non-empty for pop and non-full for push), so the clear can
            // never collide with the set above.
            if (pop) begin
                valid_q[rptr_q] <= 1'b0;
            end

            rf_we_q <= pop && head_writes;

            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (rf_we_q && (wb_count_q != 16'hFFFF)) begin
                wb_count_q <= wb_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        query_hit = rf_we_q && (rf_waddr_q == query_vd);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (vd_mem[i] == query_vd)) begin
                query_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vector_writeback.sv
// Directed testbench for vector_writeback: reset state, single write,
// full FIFO drain ordering, hazard query, push refusal while full with a
// simultaneous pop, and asynchronous reset with queued entries.
module tb_vector_writeback;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 4;

    logic        clock;
    logic        reset;
    logic [AW-1:0] query_vd;
    logic        query_hit;
    logic [15:0] wb_count;
    logic        empty;

    int tests_run;
    int tests_failed;

    vector_writeback_if #(.LANES(LANES), .WIDTH(WIDTH), .AW(AW)) bus ();

    vector_writeback #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .query_vd  (query_vd),
        .query_hit (query_hit),
        .wb_count  (wb_count),
        .empty     (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [AW-1:0] vd, input logic [31:0] data);
        bus.in_valid = 1'b1;
        bus.in_vd    = vd;
        bus.in_data  = data;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_vd    = '0;
        bus.rf_busy  = 1'b0;
`ifdef VWB_LANE_MASK_EN
        bus.in_mask  = '1;
`endif
        query_vd     = '0;

        // 1. reset with no traffic
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_rf_we",    32'(bus.rf_we),    32'd0);
        check("rst_empty",    32'(empty),        32'd1);
        check("rst_wb_count", 32'(wb_count),     32'd0);

        // 2. single write
        push_word(4'd3, 32'hA1B2C3D4);
        check("t2_latency_we", 32'(bus.rf_we), 32'd0);
        step();
        check("t2_rf_we",    32'(bus.rf_we),    32'd1);
        check("t2_rf_waddr", 32'(bus.rf_waddr), 32'd3);
        check("t2_rf_wdata", bus.rf_wdata,      32'hA1B2C3D4);
        step();
        check("t2_rf_we_off", 32'(bus.rf_we), 32'd0);
        check("t2_wb_count",  32'(wb_count),  32'd1);
        check("t2_empty",     32'(empty),     32'd1);

        // 3. fill while busy, then drain in order
        bus.rf_busy = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            push_word(AW'(v), 32'h11111111 * 32'(v));
        end
        check("t3_full_ready", 32'(bus.in_ready), 32'd0);
        bus.rf_busy = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            step();
            check("t3_drain_we",    32'(bus.rf_we),    32'd1);
            check("t3_drain_waddr", 32'(bus.rf_waddr), 32'(v));
            check("t3_drain_wdata", bus.rf_wdata,      32'h11111111 * 32'(v));
        end
        check("t3_ready_again", 32'(bus.in_ready), 32'd1);
        step();
        check("t3_we_off",    32'(bus.rf_we), 32'd0);
        check("t3_wb_count",  32'(wb_count),  32'd5);

        // 4. hazard query
        bus.rf_busy = 1'b1;
        push_word(4'd5, 32'h55555555);
        query_vd = 4'd5;
        #1;
        check("t4_hit_fifo", 32'(query_hit), 32'd1);
        query_vd = 4'd6;
        #1;
        check("t4_miss", 32'(query_hit), 32'd0);
        query_vd = 4'd5;
        bus.rf_busy = 1'b0;
        step();
        check("t4_we_vd5",    32'(bus.rf_waddr), 32'd5);
        check("t4_hit_stage", 32'(query_hit),    32'd1);
        step();
        check("t4_hit_retired", 32'(query_hit), 32'd0);
        check("t4_wb_count",    32'(wb_count),  32'd6);

        // 5. push attempt into a full FIFO in the same cycle as a pop
        bus.rf_busy = 1'b1;
        for (int v = 7; v <= 10; v++) begin
            push_word(AW'(v), 32'h01010101 * 32'(v));
        end
        bus.in_valid = 1'b1;
        bus.in_vd    = 4'd11;
        bus.in_data  = 32'hBBBBBBBB;
        bus.rf_busy  = 1'b0;
        #1;
        check("t5_refused", 32'(bus.in_ready), 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("t5_pop_vd7",   32'(bus.rf_waddr), 32'd7);
        check("t5_depth_m1",  32'(bus.in_ready), 32'd1);
        for (int v = 8; v <= 10; v++) begin
            step();
            check("t5_drain_we",    32'(bus.rf_we),    32'd1);
            check("t5_drain_waddr", 32'(bus.rf_waddr), 32'(v));
        end
        step();
        check("t5_no_vd11", 32'(bus.rf_we), 32'd0);
        check("t5_empty",   32'(empty),     32'd1);
        check("t5_wb_count", 32'(wb_count), 32'd10);

        // 6. asynchronous reset with entries queued and a write in flight
        bus.rf_busy = 1'b1;
        for (int v = 12; v <= 15; v++) begin
            push_word(AW'(v), 32'hCAFE0000 + 32'(v));
        end
        bus.rf_busy = 1'b0;
        step();
        check("t6_pre_we", 32'(bus.rf_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_we",       32'(bus.rf_we),    32'd0);
        check("t6_rst_empty",    32'(empty),        32'd1);
        check("t6_rst_ready",    32'(bus.in_ready), 32'd1);
        check("t6_rst_waddr",    32'(bus.rf_waddr), 32'd0);
        check("t6_rst_wdata",    bus.rf_wdata,      32'd0);
        check("t6_rst_wb_count", 32'(wb_count),     32'd0);
        query_vd = 4'd13;
        #1;
        check("t6_rst_hit", 32'(query_hit), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t6_no_stale_we", 32'(bus.rf_we), 32'd0);
            check("t6_still_empty", 32'(empty),     32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
